// File: rtl/iter_mul_div_pkg.sv
// rtl/iter_mul_div_pkg.sv - op codes, FSM states and op helpers for iter_mul_div
package iter_mul_div_pkg;

    localparam logic [2:0] MDU_MUL   = 3'd0;
    localparam logic [2:0] MDU_MULU  = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_MUL  = 2'd1,
        MDS_DIV  = 2'd2,
        MDS_FIX  = 2'd3
    } mds_state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Even op codes (MUL, DIV, MADD, MSUB) are the signed variants.
    function automatic logic op_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
//  rem     in   WIDTH  partial remainder before the step
//  divisor in   WIDTH  divisor magnitude
//  dbit    in   1      next dividend bit shifted into the remainder
//  rem_nxt out  WIDTH  partial remainder after the step
//  q_bit   out  1      quotient bit produced by the step
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dbit,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, dbit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // Either result is below the divisor (or is the raw shift when the
    // divisor is zero), so it always fits back into WIDTH bits.
    assign rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_mul_div.sv
// rtl/iter_mul_div.sv - iterative radix-2 multiply/divide unit writing HI/LO
//  Optional multiply-accumulate ops enabled by defining MDU_MADD_EN.
//  MDU_clk, MDU_reset (sync, active high)
//  MDU_A, MDU_B, MDU_op, MDU_start  operation request (MDU_A is also HI/LO write data)
//  MDU_HLWE, MDU_HLsrc              HI/LO write enable and HI/LO select
//  MDU_busy, MDU_done               operation in flight / one-cycle commit pulse
//  MDU_HLRD                         selected HI or LO, combinational
module iter_mul_div
    import iter_mul_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             MDU_clk,
    input  logic             MDU_reset,
    input  logic [WIDTH-1:0] MDU_A,
    input  logic [WIDTH-1:0] MDU_B,
    input  logic [2:0]       MDU_op,
    input  logic             MDU_start,
    input  logic             MDU_HLWE,
    input  logic             MDU_HLsrc,
    output logic             MDU_busy,
    output logic             MDU_done,
    output logic [WIDTH-1:0] MDU_HLRD
);

    mds_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    // MUL: {partial product high, multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opa;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi, lo;
    logic               sa, sb, is_div;
`ifdef MDU_MADD_EN
    logic               is_acc, is_sub;
`endif

    logic               op_legal, accept, a_neg, b_neg, last_iter;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH-1:0]   rem_nxt;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod_s, fix_res;
    logic [WIDTH-1:0]   quo_s, rem_s;

`ifdef MDU_MADD_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = ~MDU_op[2];
`endif

    assign accept    = (state == MDS_IDLE) && MDU_start && !MDU_HLWE && op_legal;
    assign a_neg     = op_is_signed(MDU_op) & MDU_A[WIDTH-1];
    assign b_neg     = op_is_signed(MDU_op) & MDU_B[WIDTH-1];
    assign abs_a     = a_neg ? -MDU_A : MDU_A;
    assign abs_b     = b_neg ? -MDU_B : MDU_B;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem     (acc[2*WIDTH-1:WIDTH]),
        .divisor (opa),
        .dbit    (acc[WIDTH-1]),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );
    assign div_next = {rem_nxt, acc[WIDTH-2:0], q_bit};

    assign prod_s = (sa ^ sb) ? -acc : acc;
    assign quo_s  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // With a zero divisor the remainder ends up equal to |A|, so the
    // sign fix below restores A itself for HI.
    assign rem_s  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        if (is_div)
            fix_res = {rem_s, (opa == '0) ? {WIDTH{1'b1}} : quo_s};
        else
            fix_res = prod_s;
`ifdef MDU_MADD_EN
        if (is_acc)
            fix_res = is_sub ? ({hi, lo} - prod_s) : ({hi, lo} + prod_s);
`endif
    end

    always_ff @(posedge MDU_clk) begin
        if (MDU_reset)
            state <= MDS_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MDS_IDLE: if (accept) state_nxt = op_is_div(MDU_op) ? MDS_DIV : MDS_MUL;
            MDS_MUL,
            MDS_DIV:  if (last_iter) state_nxt = MDS_FIX;
            MDS_FIX:  state_nxt = MDS_IDLE;
            default:  state_nxt = MDS_IDLE;
        endcase
    end

    always_ff @(posedge MDU_clk) begin
        if (MDU_reset) begin
            hi       <= '0;
            lo       <= '0;
            MDU_busy <= 1'b0;
            MDU_done <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opa      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            is_div   <= 1'b0;
`ifdef MDU_MADD_EN
            is_acc   <= 1'b0;
            is_sub   <= 1'b0;
`endif
        end else begin
            MDU_done <= 1'b0;
            case (state)
                MDS_IDLE: begin
                    if (MDU_HLWE) begin
                        if (MDU_HLsrc) hi <= MDU_A;
                        else           lo <= MDU_A;
                    end else if (accept) begin
                        MDU_busy <= 1'b1;
                        cnt      <= '0;
                        sa       <= a_neg;
                        sb       <= b_neg;
                        is_div   <= op_is_div(MDU_op);
`ifdef MDU_MADD_EN
                        is_acc   <= MDU_op[2];
                        is_sub   <= MDU_op[1];
`endif
                        if (op_is_div(MDU_op)) begin
                            acc <= {{WIDTH{1'b0}}, abs_a};
                            opa <= abs_b;
                        end else begin
                            acc <= {{WIDTH{1'b0}}, abs_b};
                            opa <= abs_a;
                        end
                    end
                end
                MDS_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                end
                MDS_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                end
                MDS_FIX: begin
                    {hi, lo} <= fix_res;
                    MDU_busy <= 1'b0;
                    MDU_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign MDU_HLRD = MDU_HLsrc ? hi : lo;

endmodule

// File: tb/tb_iter_mul_div.sv
// tb/tb_iter_mul_div.sv - randomized self-checking bench for iter_mul_div
module tb_iter_mul_div;

    localparam int W = 32;

    logic         MDU_clk = 1'b0;
    logic         MDU_reset;
    logic [W-1:0] MDU_A, MDU_B;
    logic [2:0]   MDU_op;
    logic         MDU_start, MDU_HLWE, MDU_HLsrc;
    logic         MDU_busy, MDU_done;
    logic [W-1:0] MDU_HLRD;

    iter_mul_div #(.WIDTH(W), .CNT_W(6)) dut (
        .MDU_clk   (MDU_clk),
        .MDU_reset (MDU_reset),
        .MDU_A     (MDU_A),
        .MDU_B     (MDU_B),
        .MDU_op    (MDU_op),
        .MDU_start (MDU_start),
        .MDU_HLWE  (MDU_HLWE),
        .MDU_HLsrc (MDU_HLsrc),
        .MDU_busy  (MDU_busy),
        .MDU_done  (MDU_done),
        .MDU_HLRD  (MDU_HLRD)
    );

    always #5 MDU_clk = ~MDU_clk;

    logic [W-1:0] m_hi, m_lo;
    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_hl(output logic [W-1:0] hi, output logic [W-1:0] lo);
        MDU_HLsrc = 1'b1;
        #1 hi = MDU_HLRD;
        MDU_HLsrc = 1'b0;
        #1 lo = MDU_HLRD;
    endtask

    task automatic check_hl(input string tag);
        logic [W-1:0] hi, lo;
        read_hl(hi, lo);
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    endtask

    // Reference: plain 64-bit arithmetic on the architectural values.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: {m_hi, m_lo} = 64'(sa * sb);
            3'd1: {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
            3'd2, 3'd3: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else if (op == 3'd2) begin
                    m_lo = W'(sa / sb);
                    m_hi = W'(sa % sb);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: begin
                p = op[0] ? ({32'b0, a} * {32'b0, b}) : 64'(sa * sb);
                {m_hi, m_lo} = op[1] ? ({m_hi, m_lo} - p) : ({m_hi, m_lo} + p);
            end
        endcase
    endtask

    task automatic hl_write(input logic src, input logic [W-1:0] val);
        @(negedge MDU_clk);
        MDU_HLWE = 1'b1; MDU_HLsrc = src; MDU_A = val;
        @(posedge MDU_clk); #1;
        MDU_HLWE = 1'b0;
        if (src) m_hi = val; else m_lo = val;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke);
        logic [W-1:0] hi, lo, ohi, olo;
        int cyc;
        bit legal;
`ifdef MDU_MADD_EN
        legal = 1'b1;
`else
        legal = (op < 3'd4);
`endif
        ohi = m_hi; olo = m_lo;
        @(negedge MDU_clk);
        MDU_op = op; MDU_A = a; MDU_B = b; MDU_start = 1'b1;
        @(posedge MDU_clk); #1;
        MDU_start = 1'b0;
        if (!legal) begin
            repeat (3) begin
                chk({tag, "_nobusy"}, 64'(MDU_busy), 64'd0);
                chk({tag, "_nodone"}, 64'(MDU_done), 64'd0);
                @(posedge MDU_clk); #1;
            end
            check_hl({tag, "_kept"});
            return;
        end
        chk({tag, "_busy"}, 64'(MDU_busy), 64'd1);
        cyc = 1;
        while (MDU_busy && cyc < 200) begin
            if (poke && cyc == 5) begin
                MDU_start = 1'b1; MDU_op = 3'd1; MDU_A = ~a; MDU_B = b + 1;
            end else begin
                MDU_start = 1'b0;
            end
            if (cyc == 3) begin
                read_hl(hi, lo);
                chk({tag, "_old"}, {hi, lo}, {ohi, olo});
                chk({tag, "_earlydone"}, 64'(MDU_done), 64'd0);
            end
            @(posedge MDU_clk); #1;
            if (MDU_busy) cyc++;
        end
        MDU_start = 1'b0;
        chk({tag, "_lat"}, 64'(cyc), 64'(W + 1));
        chk({tag, "_done"}, 64'(MDU_done), 64'd1);
        model(op, a, b);
        check_hl(tag);
        @(posedge MDU_clk); #1;
        chk({tag, "_donepulse"}, 64'(MDU_done), 64'd0);
        chk({tag, "_idle"}, 64'(MDU_busy), 64'd0);
    endtask

    initial begin
        int done_seen;
        logic [2:0] op;
        logic [W-1:0] a, b;

        MDU_reset = 1'b1; MDU_A = '0; MDU_B = '0; MDU_op = '0;
        MDU_start = 1'b0; MDU_HLWE = 1'b0; MDU_HLsrc = 1'b0;
        repeat (3) @(posedge MDU_clk);
        #1;
        MDU_reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("rst_busy", 64'(MDU_busy), 64'd0);
        chk("rst_done", 64'(MDU_done), 64'd0);
        check_hl("rst");

        run_op("mul_neg", 3'd0, -32'sd3, 32'd7, 1'b0);
        run_op("divu", 3'd3, 32'd100, 32'd7, 1'b0);
        run_op("div_neg", 3'd2, -32'sd7, 32'd2, 1'b0);
        run_op("div_zero", 3'd2, 32'd5, 32'd0, 1'b0);
        run_op("div_zero_neg", 3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);
        run_op("divu_zero", 3'd3, 32'h8000_0001, 32'd0, 1'b0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mulu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mul_minmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("poke", 3'd3, 32'd12345, 32'd17, 1'b1);

        // Reset in the middle of a DIVU aborts it with no done pulse.
        @(negedge MDU_clk);
        MDU_op = 3'd3; MDU_A = 32'd1000; MDU_B = 32'd3; MDU_start = 1'b1;
        @(negedge MDU_clk);
        MDU_start = 1'b0;
        repeat (9) @(negedge MDU_clk);
        MDU_reset = 1'b1;
        @(posedge MDU_clk); #1;
        MDU_reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("abort_busy", 64'(MDU_busy), 64'd0);
        chk("abort_done", 64'(MDU_done), 64'd0);
        check_hl("abort");
        done_seen = 0;
        repeat (40) begin
            @(posedge MDU_clk); #1;
            if (MDU_done || MDU_busy) done_seen++;
        end
        chk("abort_quiet", 64'(done_seen), 64'd0);
        run_op("after_abort", 3'd3, 32'd1000, 32'd3, 1'b0);

        // HLWE and start together: the write wins, the op is dropped.
        @(negedge MDU_clk);
        MDU_HLWE = 1'b1; MDU_HLsrc = 1'b1; MDU_A = 32'd1234; MDU_B = 32'd5;
        MDU_op = 3'd0; MDU_start = 1'b1;
        @(posedge MDU_clk); #1;
        MDU_HLWE = 1'b0; MDU_start = 1'b0;
        m_hi = 32'd1234;
        chk("hlwe_start_busy", 64'(MDU_busy), 64'd0);
        @(posedge MDU_clk); #1;
        chk("hlwe_start_busy2", 64'(MDU_busy), 64'd0);
        check_hl("hlwe_start");

        // Accumulate op: HI:LO = 0:10, MADDU 3*4.
        hl_write(1'b1, 32'd0);
        hl_write(1'b0, 32'd10);
        run_op("maddu", 3'd5, 32'd3, 32'd4, 1'b0);
        run_op("msub", 3'd6, -32'sd9, 32'd1000, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op > 3'd3 && $urandom_range(0, 2) != 0) op = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 9));
                2: b = '1;
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op("rnd", op, a, b, 1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
